// File: rtl/first_nios2_system_pkg.sv
// Shared types and constants for the sysid boot checker.
// State encoding, sysid word addresses and default build values.
package first_nios2_system_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ_ID = 3'd1,
        S_READ_TS = 3'd2,
        S_BACKOFF = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1363010471;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/first_nios2_system_sysid_timeout_ctr.sv
// Stall-cycle counter for one sysid read attempt.
// Flags expiry on the TIMEOUT_CYCLES-th consecutive stalled cycle.
module first_nios2_system_sysid_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q;

    // Count stalled cycles; restart on clear
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/first_nios2_system_sysid_checker.sv
// Avalon-MM read master that verifies the sysid ID and timestamp.
// Auto-runs after reset, re-runs on start, reports pass/fail/timeout.
module first_nios2_system_sysid_checker
    import first_nios2_system_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic        av_waitrequest,
    input  logic [31:0] av_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [1:0]  retry_count
);

    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);

    state_t     state_q;
    state_t     state_d;
    logic       word_q;
    logic [1:0] word_retries_q;

    logic rd_id;
    logic rd_ts;
    logic rd_any;
    logic xfer;
    logic tmo_exp;
    logic can_retry;
    logic go;

    assign rd_id     = (state_q == S_READ_ID);
    assign rd_ts     = (state_q == S_READ_TS);
    assign rd_any    = rd_id || rd_ts;
    assign xfer      = rd_any && !av_waitrequest;
    assign can_retry = (word_retries_q < RETRY_LIMIT);
    assign go        = start &&
                       ((state_q == S_DONE) || (state_q == S_IDLE));

    first_nios2_system_sysid_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clock  (clock),
        .reset  (reset),
        .clear  (!rd_any || xfer),
        .enable (rd_any && av_waitrequest),
        .expired(tmo_exp)
    );

    // State register; reset lands directly in READ_ID to auto-start
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_READ_ID;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and bus/status outputs; all forced low while in reset
    always_comb begin
        state_d    = state_q;
        av_read    = 1'b0;
        av_address = SYSID_ADDR_ID;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state_q)
            S_READ_ID: begin
                av_read = 1'b1;
                if (xfer) begin
                    state_d = S_READ_TS;
                end else if (tmo_exp) begin
                    state_d = can_retry ? S_BACKOFF : S_DONE;
                end
            end
            S_READ_TS: begin
                av_read    = 1'b1;
                av_address = SYSID_ADDR_TS;
                if (xfer) begin
                    state_d = S_COMPARE;
                end else if (tmo_exp) begin
                    state_d = can_retry ? S_BACKOFF : S_DONE;
                end
            end
            S_BACKOFF: begin
                state_d = (word_q == SYSID_ADDR_TS) ? S_READ_TS : S_READ_ID;
            end
            S_COMPARE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) state_d = S_READ_ID;
            end
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_READ_ID;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        if (reset) begin
            av_read    = 1'b0;
            av_address = SYSID_ADDR_ID;
            busy       = 1'b0;
            done       = 1'b0;
        end
    end

    // Capture words, track retries and timeout, register comparisons
    always_ff @(posedge clock) begin
        if (reset || go) begin
            word_q         <= SYSID_ADDR_ID;
            word_retries_q <= '0;
            retry_count    <= '0;
            timeout        <= 1'b0;
            id_ok          <= 1'b0;
            ts_ok          <= 1'b0;
            id_value       <= '0;
            ts_value       <= '0;
        end else begin
            if (xfer && rd_id) begin
                id_value       <= av_readdata;
                word_q         <= SYSID_ADDR_TS;
                word_retries_q <= '0;
            end
            if (xfer && rd_ts) begin
                ts_value <= av_readdata;
            end
            if (tmo_exp) begin
                if (can_retry) begin
                    word_retries_q <= word_retries_q + 2'd1;
                    retry_count    <= sat_inc2(retry_count);
                end else begin
                    timeout <= 1'b1;
                end
            end
            if (state_q == S_COMPARE) begin
                id_ok <= (id_value == EXPECTED_ID);
                ts_ok <= (ts_value == EXPECTED_TIMESTAMP);
            end
        end
    end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Directed bench for the sysid boot checker.
// DUT a uses default parameters, DUT b a short timeout with 2 retries.
module tb_first_nios2_system_sysid_checker;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic        reset_a, start_a, addr_a, read_a, wr_a;
    logic [31:0] rdata_a, idv_a, tsv_a;
    logic        busy_a, done_a, idok_a, tsok_a, tmo_a;
    logic [1:0]  rc_a;
    logic [31:0] id_word, ts_word;

    logic        reset_b, start_b, addr_b, read_b, wr_b;
    logic [31:0] rdata_b, idv_b, tsv_b;
    logic        busy_b, done_b, idok_b, tsok_b, tmo_b;
    logic [1:0]  rc_b;

    assign rdata_a = addr_a ? ts_word : id_word;
    assign rdata_b = 32'hFFFF_FFFF;

    first_nios2_system_sysid_checker dut_a (
        .clock(clock), .reset(reset_a), .start(start_a),
        .av_address(addr_a), .av_read(read_a),
        .av_waitrequest(wr_a), .av_readdata(rdata_a),
        .busy(busy_a), .done(done_a), .id_ok(idok_a),
        .ts_ok(tsok_a), .timeout(tmo_a), .id_value(idv_a),
        .ts_value(tsv_a), .retry_count(rc_a)
    );

    first_nios2_system_sysid_checker #(
        .TIMEOUT_CYCLES(4), .MAX_RETRIES(2)
    ) dut_b (
        .clock(clock), .reset(reset_b), .start(start_b),
        .av_address(addr_b), .av_read(read_b),
        .av_waitrequest(wr_b), .av_readdata(rdata_b),
        .busy(busy_b), .done(done_b), .id_ok(idok_b),
        .ts_ok(tsok_b), .timeout(tmo_b), .id_value(idv_b),
        .ts_value(tsv_b), .retry_count(rc_b)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_a = 1'b1; start_a = 1'b0; wr_a = 1'b0;
        reset_b = 1'b1; start_b = 1'b0; wr_b = 1'b1;
        id_word = 32'd0;
        ts_word = 32'd1363010471;
        repeat (3) tick();

        // reset state
        check("rst_read", 32'(read_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_ts", tsv_a, 32'd0);
        check("rst_b_read", 32'(read_b), 32'd0);

        // test 1: zero-wait auto-start, done 3 cycles after release
        reset_a = 1'b0;
        #1;
        check("t1_c0", {29'd0, read_a, addr_a, busy_a}, 32'b101);
        tick();
        check("t1_c1_addr", 32'(addr_a), 32'd1);
        tick();
        check("t1_c2_read", 32'(read_a), 32'd0);
        check("t1_c2_done", 32'(done_a), 32'd0);
        tick();
        check("t1_c3_done", {28'd0, done_a, busy_a, idok_a, tsok_a},
              32'b1011);
        check("t1_ts", tsv_a, 32'd1363010471);
        check("t1_rc", 32'(rc_a), 32'd0);

        // test 2 + 6: start in DONE, start held while busy ignored
        ts_word = 32'h1234_5678;
        start_a = 1'b1;
        tick();
        check("t6_go", {28'd0, busy_a, done_a, read_a, addr_a},
              32'b1010);
        check("t6_clr_ok", {30'd0, idok_a, tsok_a}, 32'd0);
        check("t6_clr_ts", tsv_a, 32'd0);
        tick();
        start_a = 1'b0;
        check("t6_ignored", 32'(addr_a), 32'd1);
        tick();
        tick();
        check("t2_done", 32'(done_a), 32'd1);
        check("t2_ok", {29'd0, idok_a, tsok_a, tmo_a}, 32'b100);
        check("t2_ts", tsv_a, 32'h1234_5678);

        // test 3: ID read stalled 10 cycles
        ts_word = 32'd1363010471;
        wr_a = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            check($sformatf("t3_stall%0d", i),
                  {29'd0, read_a, addr_a, busy_a}, 32'b101);
            tick();
        end
        wr_a = 1'b0;
        check("t3_c11", {29'd0, read_a, addr_a, busy_a}, 32'b101);
        tick();
        check("t3_ts_addr", 32'(addr_a), 32'd1);
        tick();
        tick();
        check("t3_done", {28'd0, done_a, idok_a, tsok_a, tmo_a},
              32'b1110);
        check("t3_rc", 32'(rc_a), 32'd0);

        // test 5: reset during a stalled TS read
        id_word = 32'h0000_00AA;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        check("t5_idcap", idv_a, 32'h0000_00AA);
        wr_a = 1'b1;
        tick();
        tick();
        check("t5_stall", {30'd0, read_a, addr_a}, 32'b11);
        reset_a = 1'b1;
        tick();
        check("t5_rst_bus", {29'd0, read_a, busy_a, done_a}, 32'd0);
        check("t5_rst_id", idv_a, 32'd0);
        reset_a = 1'b0;
        id_word = 32'd0;
        wr_a = 1'b0;
        #1;
        check("t5_restart", {30'd0, busy_a, read_a}, 32'b11);
        tick();
        tick();
        tick();
        check("t5_pass", {29'd0, done_a, idok_a, tsok_a}, 32'b111);

        // test 4: stuck waitrequest, 3 bursts of 4 with 1-cycle gaps
        reset_b = 1'b0;
        #1;
        for (int i = 0; i < 15; i++) begin
            logic e;
            e = !(i == 4 || i == 9 || i == 14);
            check($sformatf("t4_read%0d", i),
                  {30'd0, read_b, addr_b}, {30'd0, e, 1'b0});
            tick();
        end
        check("t4_done", {29'd0, done_b, busy_b, tmo_b}, 32'b101);
        check("t4_ok", {30'd0, idok_b, tsok_b}, 32'd0);
        check("t4_rc", 32'(rc_b), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
